// File: rtl/mips_defs.sv
// mips_defs: shared ALU, mul/div and forwarding codes, mul/div FSM states
// and the default datapath width for the execute stage.
package mips_defs;
  localparam int DEF_DATA_W = 32;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;
  localparam logic [1:0] FWD_RD = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;
  typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_RUN = 2'd1, MD_FIX = 2'd2} md_state_e;
  function automatic logic md_signed(input logic [1:0] op);
    return op == MD_MULT || op == MD_DIV;
  endfunction
  function automatic logic md_is_div(input logic [1:0] op);
    return op == MD_DIV || op == MD_DIVU;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative mult/multu/div/divu on magnitudes with HI/LO;
// DATA_W shift steps followed by one sign-fix cycle that writes HI/LO.
module muldiv_unit
  import mips_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              busy_o
);
  localparam int CW = $clog2(DATA_W);
  md_state_e state_q;
  logic [CW-1:0] cnt_q;
  logic div_q, neg_q, negr_q, zero_q;
  logic [DATA_W-1:0] acc_q, q_q, m_q, a_q, hi_q, lo_q;
  logic a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W:0] sum, sh, diff;
  logic ge;
  logic [2*DATA_W-1:0] prod;
  assign a_neg = md_signed(op_i) & a_i[DATA_W-1];
  assign b_neg = md_signed(op_i) & b_i[DATA_W-1];
  assign a_mag = a_neg ? -a_i : a_i;
  assign b_mag = b_neg ? -b_i : b_i;
  assign sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
  // restoring divide: remainder < divisor, so bit DATA_W of the difference is the borrow
  assign sh = {acc_q, q_q[DATA_W-1]};
  assign diff = sh - {1'b0, m_q};
  assign ge = ~diff[DATA_W];
  assign prod = neg_q ? -{acc_q, q_q} : {acc_q, q_q};
  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign busy_o = state_q != MD_IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q <= '0;
      {div_q, neg_q, negr_q, zero_q} <= '0;
      acc_q <= '0;
      q_q <= '0;
      m_q <= '0;
      a_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else if (state_q == MD_IDLE && start_i) begin
      state_q <= MD_RUN;
      cnt_q <= CW'(DATA_W - 1);
      div_q <= md_is_div(op_i);
      neg_q <= a_neg ^ b_neg;
      negr_q <= a_neg;
      zero_q <= b_i == '0;
      a_q <= a_i;
      acc_q <= '0;
      q_q <= md_is_div(op_i) ? a_mag : b_mag;
      m_q <= md_is_div(op_i) ? b_mag : a_mag;
    end else if (state_q == MD_RUN) begin
      acc_q <= div_q ? (ge ? diff[DATA_W-1:0] : sh[DATA_W-1:0]) : sum[DATA_W:1];
      q_q <= div_q ? {q_q[DATA_W-2:0], ge} : {sum[0], q_q[DATA_W-1:1]};
      cnt_q <= cnt_q - 1'b1;
      state_q <= cnt_q == '0 ? MD_FIX : MD_RUN;
    end else if (state_q == MD_FIX) begin
      hi_q <= div_q ? (zero_q ? a_q : (negr_q ? -acc_q : acc_q)) : prod[2*DATA_W-1:DATA_W];
      lo_q <= div_q ? (zero_q ? '1 : (neg_q ? -q_q : q_q)) : prod[DATA_W-1:0];
      state_q <= MD_IDLE;
    end
  end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: MIPS E stage with forwarding, ALU and E/M register.
// MULDIV_EN adds the iterative mul/div unit, HI/LO and the MDStall hazard.
module execute_stage
  import mips_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteE,
  input  logic              MemtoRegE,
  input  logic              MemWriteE,
  input  logic              ALUSrcE,
  input  logic              RegDstE,
  input  logic [2:0]        ALUControlE,
  input  logic              MulDivStartE,
  input  logic [1:0]        MulDivOpE,
  input  logic              MfhiE,
  input  logic              MfloE,
  input  logic [DATA_W-1:0] RD1E,
  input  logic [DATA_W-1:0] RD2E,
  input  logic [DATA_W-1:0] SignImmE,
  input  logic [4:0]        RtE,
  input  logic [4:0]        RdE,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [DATA_W-1:0] ResultW,
  output logic [4:0]        WriteRegE,
  output logic              MDStall,
  output logic              RegWriteM,
  output logic              MemtoRegM,
  output logic              MemWriteM,
  output logic [DATA_W-1:0] ALUOutM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [4:0]        WriteRegM
);
  logic [DATA_W-1:0] src_a, src_b, write_data, alu, res;
  assign src_a = ForwardAE == FWD_W ? ResultW : ForwardAE == FWD_M ? ALUOutM : RD1E;
  assign write_data = ForwardBE == FWD_W ? ResultW : ForwardBE == FWD_M ? ALUOutM : RD2E;
  assign src_b = ALUSrcE ? SignImmE : write_data;
  assign WriteRegE = RegDstE ? RdE : RtE;
  assign alu = ALUControlE == ALU_ADD ? src_a + src_b :
               ALUControlE == ALU_SUB ? src_a - src_b :
               ALUControlE == ALU_AND ? src_a & src_b :
               ALUControlE == ALU_OR  ? src_a | src_b :
               ALUControlE == ALU_SLT ? {{(DATA_W-1){1'b0}}, $signed(src_a) < $signed(src_b)} :
               ALUControlE == ALU_NOR ? ~(src_a | src_b) : '0;
`ifdef MULDIV_EN
  logic [DATA_W-1:0] hi, lo;
  logic busy;
  muldiv_unit #(.DATA_W(DATA_W)) u_md (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (MulDivStartE),
    .op_i    (MulDivOpE),
    .a_i     (src_a),
    .b_i     (write_data),
    .hi_o    (hi),
    .lo_o    (lo),
    .busy_o  (busy)
  );
  assign MDStall = busy & (MfhiE | MfloE | MulDivStartE);
  assign res = MfhiE ? hi : MfloE ? lo : alu;
`else
  logic unused_md;
  assign unused_md = ^{MulDivStartE, MulDivOpE};
  assign MDStall = 1'b0;
  assign res = (MfhiE | MfloE) ? '0 : alu;
`endif
  // a stalled E instruction leaves a zeroed bubble in M
  always_ff @(posedge clk) begin
    if (!rst_n || MDStall) begin
      RegWriteM <= 1'b0;
      MemtoRegM <= 1'b0;
      MemWriteM <= 1'b0;
      ALUOutM <= '0;
      WriteDataM <= '0;
      WriteRegM <= '0;
    end else begin
      RegWriteM <= RegWriteE;
      MemtoRegM <= MemtoRegE;
      MemWriteM <= MemWriteE;
      ALUOutM <= res;
      WriteDataM <= write_data;
      WriteRegM <= WriteRegE;
    end
  end
endmodule
